// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register file,
// serves two ID read ports with write-through bypass and counts retired instructions.
module wb_regfile #(
  parameter int DW    = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WB_VALID,
  input  logic [DW-1:0]    WB_ALU_RES,
  input  logic [DW-1:0]    WB_DM_Q,
  input  logic [DW-1:0]    WB_PC_PLUS4,
  input  logic [1:0]       WB_RF_D_SEL,
  input  logic             WB_RF_WE,
  input  logic [AW-1:0]    WB_RF_WA,
  input  logic [AW-1:0]    ID_RS1_ADDR,
  input  logic [AW-1:0]    ID_RS2_ADDR,
  output logic [DW-1:0]    ID_RS1_DATA,
  output logic [DW-1:0]    ID_RS2_DATA,
  output logic [DW-1:0]    WB_WDATA,
  output logic [CNT_W-1:0] WB_RETIRE_CNT
);

  logic [DW-1:0]    rf_q [NREG];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             commit;
  logic             bypass_en;

  always_comb begin
    case (WB_RF_D_SEL)
      2'b01:   WB_WDATA = WB_DM_Q;
      2'b10:   WB_WDATA = WB_PC_PLUS4;
      default: WB_WDATA = WB_ALU_RES;
    endcase
  end

  // x0 is never written, so its storage stays at the reset value of zero.
  assign commit    = WB_VALID & WB_RF_WE & (WB_RF_WA != '0);
  assign bypass_en = commit & rst_n;

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    logic [DW-1:0] data;
    data = '0;
    if (addr != '0) begin
      if (bypass_en && (addr == WB_RF_WA)) begin
        data = WB_WDATA;
      end else begin
        data = rf_q[addr];
      end
    end
    return data;
  endfunction

  always_comb begin
    ID_RS1_DATA = read_port(ID_RS1_ADDR);
    ID_RS2_DATA = read_port(ID_RS2_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit) begin
      rf_q[WB_RF_WA] <= WB_WDATA;
    end
  end

  // Bubbles do not retire; every real instruction does, written or not.
  assign cnt_d = WB_VALID ? (cnt_q + CNT_W'(1)) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WB_RETIRE_CNT = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver pushes expected outputs per cycle,
// a negedge monitor pops and compares them against two DUT instances.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wbValid;
  logic [31:0] wbAluRes;
  logic [31:0] wbDmQ;
  logic [31:0] wbPcPlus4;
  logic [1:0]  wbSel;
  logic        wbWe;
  logic [4:0]  wbWa;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] wData;
  logic [31:0] retireCnt;
  logic [31:0] smallRs1Data;
  logic [31:0] smallRs2Data;
  logic [31:0] smallWData;
  logic [3:0]  smallRetireCnt;

  typedef struct {
    int          cycle;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wdata;
    logic [31:0] cnt;
    logic [3:0]  cntSmall;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelRegs [32];
  logic [31:0] modelCnt;
  int          cycleNum;
  int          checks;
  int          fails;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .WB_VALID(wbValid), .WB_ALU_RES(wbAluRes),
    .WB_DM_Q(wbDmQ), .WB_PC_PLUS4(wbPcPlus4), .WB_RF_D_SEL(wbSel),
    .WB_RF_WE(wbWe), .WB_RF_WA(wbWa), .ID_RS1_ADDR(rs1Addr),
    .ID_RS2_ADDR(rs2Addr), .ID_RS1_DATA(rs1Data), .ID_RS2_DATA(rs2Data),
    .WB_WDATA(wData), .WB_RETIRE_CNT(retireCnt)
  );

  wb_regfile #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .WB_VALID(wbValid), .WB_ALU_RES(wbAluRes),
    .WB_DM_Q(wbDmQ), .WB_PC_PLUS4(wbPcPlus4), .WB_RF_D_SEL(wbSel),
    .WB_RF_WE(wbWe), .WB_RF_WA(wbWa), .ID_RS1_ADDR(rs1Addr),
    .ID_RS2_ADDR(rs2Addr), .ID_RS1_DATA(smallRs1Data), .ID_RS2_DATA(smallRs2Data),
    .WB_WDATA(smallWData), .WB_RETIRE_CNT(smallRetireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Inputs change just after posedge, so the negedge sample sees settled values.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("rs1_data", e.cycle, rs1Data, e.rs1);
      checkOutput("rs2_data", e.cycle, rs2Data, e.rs2);
      checkOutput("wdata", e.cycle, wData, e.wdata);
      checkOutput("retire_cnt", e.cycle, retireCnt, e.cnt);
      checkOutput("retire_cnt4", e.cycle, {28'd0, smallRetireCnt}, {28'd0, e.cntSmall});
      checkOutput("small_rs1", e.cycle, smallRs1Data, e.rs1);
      checkOutput("small_wdata", e.cycle, smallWData, e.wdata);
    end
  end

  function automatic logic [31:0] modelRead(input logic [4:0] addr, input logic pending,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'd0;
    if (pending && addr == wa) return wd;
    return modelRegs[addr];
  endfunction

  task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] sel,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] alu, input logic [31:0] dm,
                               input logic [31:0] pc, input logic [4:0] ra1,
                               input logic [4:0] ra2);
    exp_t        e;
    logic [31:0] wd;
    logic        pending;
    @(posedge clk);
    #1;
    rst_n = rst; wbValid = valid; wbSel = sel; wbWe = we; wbWa = wa;
    wbAluRes = alu; wbDmQ = dm; wbPcPlus4 = pc; rs1Addr = ra1; rs2Addr = ra2;
    cycleNum++;
    if (!rst) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      modelCnt = 32'd0;
    end
    wd = (sel == 2'd1) ? dm : (sel == 2'd2) ? pc : alu;
    pending = rst && valid && we && (wa != 5'd0);
    e.cycle    = cycleNum;
    e.rs1      = modelRead(ra1, pending, wa, wd);
    e.rs2      = modelRead(ra2, pending, wa, wd);
    e.wdata    = wd;
    e.cnt      = modelCnt;
    e.cntSmall = modelCnt[3:0];
    expQ.push_back(e);
    if (pending) modelRegs[wa] = wd;
    if (rst && valid) modelCnt = modelCnt + 32'd1;
  endtask

  initial begin
    checks = 0; fails = 0; cycleNum = 0; modelCnt = 32'd0;
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    rst_n = 1'b1; wbValid = 1'b0; wbSel = 2'd0; wbWe = 1'b0; wbWa = 5'd0;
    wbAluRes = 32'd0; wbDmQ = 32'd0; wbPcPlus4 = 32'd0; rs1Addr = 5'd0; rs2Addr = 5'd0;
    #2 rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd31);

    // Source select: each write lands in x5 and is read back the next cycle.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 1'b1, 2'(s), 1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd1);
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
    end

    // x0 writes are dropped and never bypassed.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 5'd0, 32'hDEAD, 32'h0, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5);

    // Both ports bypass the same destination, then read the stored value.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 5'd7, 32'hCAFE, 32'h1, 32'h2, 5'd7, 5'd7);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);

    // Bubble with WE: no write, no bypass, no count; then a valid non-writing op.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 5'd3, 32'h3333, 32'h0, 32'h0, 5'd3, 5'd3);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 5'd3, 32'hBAD0, 32'h0, 32'h0, 5'd3, 5'd3);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 5'd3, 32'hBAD1, 32'h0, 32'h0, 5'd3, 5'd7);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7);

    // Mid-run reset clears state before any clock edge can act.
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 5'd0, 32'h5, 32'h6, 32'h7, 5'd5, 5'd7);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7);

    // Seventeen retirements wrap the 4-bit counter to 1.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 1'(k % 2), 5'(k + 1), $urandom, 32'h0, 32'h0,
                    5'(k), 5'(k + 1));
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd4);

    for (int k = 0; k < 400; k++) begin
      logic [4:0] wa;
      logic [4:0] ra1;
      logic [4:0] ra2;
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), wa,
                    $urandom, $urandom, $urandom, ra1, ra2);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
